// File: rtl/count_pwm_compare.sv
// PWM comparator fed by a free-running counter: wrap detection, period-aligned
// duty updates through a shadow register, and a saturating period counter.
module count_pwm_compare #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic [N-1:0] Count,
    input  logic         Enable,
    input  logic [N-1:0] Duty_in,
    input  logic         Duty_load,
    output logic         Pwm_out,
    output logic         Wrap_pulse,
    output logic [N-1:0] Duty_active,
    output logic [W-1:0] Wrap_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t         state_reg;
    logic [N-1:0]   count_prev_reg;
    logic [N-1:0]   shadow_reg;
    logic           shadow_valid_reg;
    logic [N-1:0]   duty_active_reg;
    logic           pwm_reg;
    logic           wrap_pulse_reg;
    logic [W-1:0]   wrap_count_reg;

    logic           wrap;
    logic [N-1:0]   duty_eff;
    logic           pwm_cmp;

    // A drop in Count marks a period boundary, whether a natural rollover
    // or the upstream counter being reset part-way through a period.
    always_comb begin
        wrap     = (Count < count_prev_reg);
        duty_eff = duty_active_reg;
        if (wrap) begin
            if (Duty_load)
                duty_eff = Duty_in;
            else if (shadow_valid_reg)
                duty_eff = shadow_reg;
        end
        pwm_cmp = (Count < duty_eff);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg        <= IDLE;
            count_prev_reg   <= '0;
            shadow_reg       <= '0;
            shadow_valid_reg <= 1'b0;
            duty_active_reg  <= '0;
            pwm_reg          <= 1'b0;
            wrap_pulse_reg   <= 1'b0;
            wrap_count_reg   <= '0;
        end else begin
            count_prev_reg  <= Count;
            wrap_pulse_reg  <= wrap;
            duty_active_reg <= duty_eff;

            if (Duty_load)
                shadow_reg <= Duty_in;
            // A wrap consumes any pending shadow value, including one loaded
            // on the wrap cycle itself (that value is applied directly).
            if (wrap)
                shadow_valid_reg <= 1'b0;
            else if (Duty_load)
                shadow_valid_reg <= 1'b1;

            if (wrap && Enable && (wrap_count_reg != {W{1'b1}}))
                wrap_count_reg <= wrap_count_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    pwm_reg <= 1'b0;
                    if (Enable)
                        state_reg <= SYNC;
                end
                SYNC: begin
                    if (!Enable) begin
                        pwm_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else if (wrap) begin
                        pwm_reg   <= pwm_cmp;
                        state_reg <= RUN;
                    end else begin
                        pwm_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (!Enable) begin
                        pwm_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        pwm_reg <= pwm_cmp;
                    end
                end
                default: begin
                    pwm_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign Pwm_out     = pwm_reg;
    assign Wrap_pulse  = wrap_pulse_reg;
    assign Duty_active = duty_active_reg;
    assign Wrap_count  = wrap_count_reg;

endmodule

// File: tb/tb_count_pwm_compare.sv
// Bench for count_pwm_compare: per-cycle scoreboard against a reference model,
// period-level table of hand-derived expectations, plus reset and saturation sequences.
module tb_count_pwm_compare;

    logic       clk;
    logic       reset_n;
    logic [3:0] count;
    logic       enable;
    logic [3:0] duty_in;
    logic       duty_load;
    logic       pwm_out,  pwm_out2;
    logic       wrap_pulse, wrap_pulse2;
    logic [3:0] duty_active, duty_active2;
    logic [7:0] wrap_count;
    logic [1:0] wrap_count2;

    int checks = 0;
    int errors = 0;

    count_pwm_compare #(.N(4), .W(8)) dut (
        .Clk(clk), .Reset_n(reset_n), .Count(count), .Enable(enable),
        .Duty_in(duty_in), .Duty_load(duty_load), .Pwm_out(pwm_out),
        .Wrap_pulse(wrap_pulse), .Duty_active(duty_active), .Wrap_count(wrap_count)
    );

    // Narrow period counter instance used for the saturation sequence.
    count_pwm_compare #(.N(4), .W(2)) dut2 (
        .Clk(clk), .Reset_n(reset_n), .Count(count), .Enable(enable),
        .Duty_in(duty_in), .Duty_load(duty_load), .Pwm_out(pwm_out2),
        .Wrap_pulse(wrap_pulse2), .Duty_active(duty_active2), .Wrap_count(wrap_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       pwm;
        logic       wp;
        logic [3:0] duty;
        logic [7:0] wc;
        logic [1:0] wc2;
    } exp_t;
    exp_t sb[$];

    // Reference model state
    int         m_state;   // 0 idle, 1 sync, 2 run
    logic [3:0] m_prev, m_duty, m_sh;
    logic       m_shv, m_pwm, m_wp;
    int         m_wc, m_wc2;

    task automatic model_reset();
        m_state = 0; m_prev = 0; m_duty = 0; m_sh = 0;
        m_shv = 0; m_pwm = 0; m_wp = 0; m_wc = 0; m_wc2 = 0;
        sb.delete();
    endtask

    task automatic model_step(input logic [3:0] c, input logic en,
                              input logic [3:0] din, input logic ld);
        logic       w;
        logic [3:0] de;
        exp_t       e;
        w  = (c < m_prev);
        de = m_duty;
        if (w && ld)          de = din;
        else if (w && m_shv)  de = m_sh;
        if (!en)                   m_pwm = 0;
        else if (m_state == 2)     m_pwm = (c < de);
        else if (m_state == 1 && w) m_pwm = (c < de);
        else                       m_pwm = 0;
        if (!en)                    m_state = 0;
        else if (m_state == 0)      m_state = 1;
        else if (m_state == 1 && w) m_state = 2;
        if (w && en) begin
            if (m_wc < 255) m_wc++;
            if (m_wc2 < 3)  m_wc2++;
        end
        if (ld) m_sh = din;
        m_shv  = w ? 1'b0 : (ld ? 1'b1 : m_shv);
        m_duty = de;
        m_prev = c;
        m_wp   = w;
        e.pwm = m_pwm; e.wp = m_wp; e.duty = m_duty;
        e.wc = 8'(m_wc); e.wc2 = 2'(m_wc2);
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: drive at negedge, predict, then compare one cycle later.
    task automatic tick(input logic [3:0] c, input logic en,
                        input logic [3:0] din, input logic ld);
        exp_t e;
        @(negedge clk);
        count = c; enable = en; duty_in = din; duty_load = ld;
        model_step(c, en, din, ld);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("pwm_out",     int'(pwm_out),     int'(e.pwm));
            chk("wrap_pulse",  int'(wrap_pulse),  int'(e.wp));
            chk("duty_active", int'(duty_active), int'(e.duty));
            chk("wrap_count",  int'(wrap_count),  int'(e.wc));
            chk("wrap_count2", int'(wrap_count2), int'(e.wc2));
        end
        duty_load = 1'b0;
    endtask

    typedef struct {
        bit         restart;   // upstream counter forced to 0 before this phase
        bit         en;
        int         load_at;   // cycle index of Duty_load strobe, -1 none
        logic [3:0] din;
        int         cycles;
        int         exp_high;  // Pwm_out high samples for counts driven here
        int         exp_wraps;
        logic [3:0] exp_duty;  // Duty_active at end of phase
    } phase_t;

    phase_t tbl [14];
    logic [3:0] cnt;
    int highs, wraps;
    int exp_wc2 [5];

    initial begin
        tbl[0]  = '{0, 0,  2, 4'd5,   9,  0, 0, 4'd0};   // load while idle
        tbl[1]  = '{0, 1, -1, 4'd0,   7,  0, 0, 4'd0};   // enable mid-period: sync
        tbl[2]  = '{0, 1, -1, 4'd0,  16,  5, 1, 4'd5};   // first full period
        tbl[3]  = '{0, 1,  7, 4'd12, 16,  5, 1, 4'd5};   // load mid-period, old duty kept
        tbl[4]  = '{0, 1, -1, 4'd0,  16, 12, 1, 4'd12};
        tbl[5]  = '{0, 1,  0, 4'd0,  16,  0, 1, 4'd0};   // load on wrap, duty 0
        tbl[6]  = '{0, 1,  0, 4'd15, 16, 15, 1, 4'd15};  // load on wrap, duty max
        tbl[7]  = '{0, 1, -1, 4'd0,  16, 15, 1, 4'd15};
        tbl[8]  = '{0, 1,  3, 4'd3,  10, 10, 1, 4'd15};  // pending shadow
        tbl[9]  = '{1, 1, -1, 4'd0,  16,  3, 1, 4'd3};   // upstream reset at Count=9
        tbl[10] = '{0, 1, -1, 4'd0,   2,  2, 1, 4'd3};
        tbl[11] = '{0, 0, -1, 4'd0,   4,  0, 0, 4'd3};   // disable mid-run
        tbl[12] = '{0, 1, -1, 4'd0,  10,  0, 0, 4'd3};   // re-sync
        tbl[13] = '{0, 1, -1, 4'd0,  16,  3, 1, 4'd3};
        exp_wc2 = '{1, 2, 3, 3, 3};

        reset_n = 1'b0; count = 0; enable = 0; duty_in = 0; duty_load = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pwm",   int'(pwm_out),     0);
        chk("reset_wp",    int'(wrap_pulse),  0);
        chk("reset_duty",  int'(duty_active), 0);
        chk("reset_wc",    int'(wrap_count),  0);
        @(negedge clk);
        reset_n = 1'b1;

        cnt = 0;
        for (int p = 0; p < 14; p++) begin
            if (tbl[p].restart) cnt = 0;
            highs = 0; wraps = 0;
            for (int i = 0; i < tbl[p].cycles; i++) begin
                tick(cnt, tbl[p].en, tbl[p].din, (tbl[p].load_at == i));
                highs += int'(pwm_out);
                wraps += int'(wrap_pulse);
                cnt = cnt + 4'd1;
            end
            chk($sformatf("phase%0d_high", p),  highs, tbl[p].exp_high);
            chk($sformatf("phase%0d_wraps", p), wraps, tbl[p].exp_wraps);
            chk($sformatf("phase%0d_duty", p),  int'(duty_active), int'(tbl[p].exp_duty));
            $display("phase %0d: en=%0b high=%0d wraps=%0d duty=%0d wrap_count=%0d",
                     p, tbl[p].en, highs, wraps, duty_active, wrap_count);
        end
        chk("wrap_count_total", int'(wrap_count),  10);
        chk("wrap_count2_sat",  int'(wrap_count2), 3);

        // Asynchronous reset mid-period while Pwm_out is high.
        tick(cnt, 1'b1, 4'd0, 1'b0); cnt = cnt + 4'd1;
        tick(cnt, 1'b1, 4'd0, 1'b0); cnt = cnt + 4'd1;
        chk("pre_reset_pwm", int'(pwm_out), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_pwm",  int'(pwm_out),     0);
        chk("async_reset_wp",   int'(wrap_pulse),  0);
        chk("async_reset_duty", int'(duty_active), 0);
        chk("async_reset_wc",   int'(wrap_count),  0);
        chk("async_reset_wc2",  int'(wrap_count2), 0);
        $display("async reset applied mid-period at count=%0d", cnt - 4'd1);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Finish the partial period, then five whole periods for saturation.
        while (cnt != 4'd0) begin
            tick(cnt, 1'b1, 4'd0, 1'b0);
            cnt = cnt + 4'd1;
        end
        chk("post_reset_wc", int'(wrap_count), 0);
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 16; i++) begin
                tick(cnt, 1'b1, 4'd0, 1'b0);
                cnt = cnt + 4'd1;
            end
            chk($sformatf("sat_period%0d_wc2", p), int'(wrap_count2), exp_wc2[p]);
            chk($sformatf("sat_period%0d_wc", p),  int'(wrap_count),  p + 1);
            $display("period %0d: wrap_count=%0d wrap_count(W=2)=%0d",
                     p, wrap_count, wrap_count2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
